// File: rtl/ex_muldiv.sv
// ex_muldiv -- multi-cycle RV64M execute unit sitting beside the EX-stage ALU.
//
// Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and the W forms. While an
// op is in flight it raises stallreq_ex so IF..EX freeze; the result is put on
// the EX->MEM bus in the DONE cycle (res_valid high, stallreq_ex low).
//
// Ports
//   clk          clock
//   rst_n        synchronous active-low reset
//   start        EX holds a decoded M-op with forwarded operands
//   op           0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   word         W variant (operands narrowed to 32 bits, result sign-extended)
//   src1, src2   forwarded rs1 / rs2 values
//   flush        kill any in-flight op (wins over start)
//   hold         downstream stall; keeps DONE and the result frozen
//   stallreq_ex  pipeline freeze request
//   res_valid    result valid this cycle
//   result       final rd value, held until the next completion
module ex_muldiv #(
    parameter int XLEN     = 64,
    parameter int MUL_LAT  = 3,
    parameter int DIV_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    input  logic            hold,
    output logic            stallreq_ex,
    output logic            res_valid,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int WS   = XLEN - 32;
    localparam int CMAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
    localparam int CW   = $clog2(CMAX) + 1;

    localparam logic [CW-1:0]   CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]   MUL_CNT   = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0]   DIV_CNT_D = CW'(XLEN / DIV_STEP - 1);
    localparam logic [CW-1:0]   DIV_CNT_W = CW'(32 / DIV_STEP - 1);
    localparam logic [XLEN-1:0] ONES      = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO      = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONE       = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] XMIN      = {1'b1, {(XLEN-1){1'b0}}};

    // Sign-extend the low 32 bits to XLEN.
    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        logic signed [XLEN-1:0] t;
        t = $signed(v << WS);
        return t >>> WS;
    endfunction

    // Zero-extend the low 32 bits to XLEN.
    function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
        return (v << WS) >> WS;
    endfunction

    // Two's complement negate.
    function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] v);
        return ~v + ONE;
    endfunction

    // Ops whose operands are treated as signed for W extension and divide.
    function automatic logic op_signed(input logic [2:0] o);
        logic s;
        case (o)
            3'd0, 3'd1, 3'd2, 3'd4, 3'd6: s = 1'b1;
            default:                      s = 1'b0;
        endcase
        return s;
    endfunction

    // Narrow an operand for W ops; full-width ops pass through.
    function automatic logic [XLEN-1:0] ext_operand(input logic [XLEN-1:0] v,
                                                    input logic w, input logic sg);
        logic [XLEN-1:0] r;
        if (!w) begin
            r = v;
        end else if (sg) begin
            r = sext32(v);
        end else begin
            r = zext32(v);
        end
        return r;
    endfunction

    // Signed MIN / -1 on already-extended operands, in the op's own width.
    function automatic logic div_ovf(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                     input logic w, input logic [2:0] o);
        logic [XLEN-1:0] min_v;
        min_v = w ? sext32(XMIN >> WS) : XMIN;
        return o[2] & ~o[0] & (b == ONES) & (a == min_v);
    endfunction

    state_t          state_r;
    logic [2:0]      op_r;
    logic            word_r;
    logic [XLEN-1:0] a_r;
    logic [XLEN-1:0] b_r;
    logic [XLEN-1:0] q_r;
    logic [XLEN-1:0] rem_r;
    logic [XLEN-1:0] dvs_r;
    logic [CW-1:0]   cnt_r;
    logic            fin_r;

    logic [XLEN-1:0]   ea_s;
    logic [XLEN-1:0]   eb_s;
    logic              in_sg_s;
    logic              in_special_s;
    logic [XLEN-1:0]   mag_a_s;
    logic [XLEN-1:0]   mag_b_s;
    logic [2*XLEN-1:0] ma_s;
    logic [2*XLEN-1:0] mb_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   mul_raw_s;
    logic [XLEN-1:0]   mul_res_s;
    logic [XLEN:0]     sh_s;
    logic [XLEN:0]     diff_s;
    logic [XLEN-1:0]   q_nxt_s;
    logic [XLEN-1:0]   rem_nxt_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rmd_s;
    logic [XLEN-1:0]   div_raw_s;
    logic [XLEN-1:0]   div_res_s;

    // Freeze request: accepting a start, or an op still computing.
    assign stallreq_ex = ((state_r == S_IDLE) & start & ~flush) |
                         (state_r == S_MUL) | (state_r == S_DIV);

    // Incoming operand extension, magnitudes and special-case detection.
    always_comb begin
        in_sg_s      = op_signed(op);
        ea_s         = ext_operand(src1, word, in_sg_s);
        eb_s         = ext_operand(src2, word, in_sg_s);
        in_special_s = (eb_s == ZERO) | div_ovf(ea_s, eb_s, word, op);
        if (in_sg_s & ea_s[XLEN-1]) begin
            mag_a_s = neg(ea_s);
        end else begin
            mag_a_s = ea_s;
        end
        if (in_sg_s & eb_s[XLEN-1]) begin
            mag_b_s = neg(eb_s);
        end else begin
            mag_b_s = eb_s;
        end
    end

    // Product of the latched operands; sign extension chosen per op so the
    // low 2*XLEN bits carry the correctly signed product.
    always_comb begin
        ma_s   = {{XLEN{((op_r == 3'd1) | (op_r == 3'd2)) & a_r[XLEN-1]}}, a_r};
        mb_s   = {{XLEN{(op_r == 3'd1) & b_r[XLEN-1]}}, b_r};
        prod_s = ma_s * mb_s;
        if (op_r == 3'd0) begin
            mul_raw_s = prod_s[XLEN-1:0];
        end else begin
            mul_raw_s = prod_s[2*XLEN-1:XLEN];
        end
        if (word_r) begin
            mul_res_s = sext32(mul_raw_s);
        end else begin
            mul_res_s = mul_raw_s;
        end
    end

    // DIV_STEP restoring-divide iterations on magnitudes. The partial
    // remainder stays below the divisor, so the XLEN-bit register never
    // loses its top bit on a restore.
    always_comb begin
        rem_nxt_s = rem_r;
        q_nxt_s   = q_r;
        sh_s      = {(XLEN+1){1'b0}};
        diff_s    = {(XLEN+1){1'b0}};
        for (int i = 0; i < DIV_STEP; i++) begin
            sh_s    = {rem_nxt_s, q_nxt_s[XLEN-1]};
            q_nxt_s = {q_nxt_s[XLEN-2:0], 1'b0};
            diff_s  = sh_s - {1'b0, dvs_r};
            if (!diff_s[XLEN]) begin
                rem_nxt_s  = diff_s[XLEN-1:0];
                q_nxt_s[0] = 1'b1;
            end else begin
                rem_nxt_s = sh_s[XLEN-1:0];
            end
        end
    end

    // Final divide result: ISA special cases, then sign fix-up of the
    // magnitude quotient/remainder, then W narrowing.
    always_comb begin
        if (b_r == ZERO) begin
            quo_s = ONES;
            rmd_s = a_r;
        end else if (div_ovf(a_r, b_r, word_r, op_r)) begin
            quo_s = a_r;
            rmd_s = ZERO;
        end else begin
            if (~op_r[0] & (a_r[XLEN-1] ^ b_r[XLEN-1])) begin
                quo_s = neg(q_r);
            end else begin
                quo_s = q_r;
            end
            if (~op_r[0] & a_r[XLEN-1]) begin
                rmd_s = neg(rem_r);
            end else begin
                rmd_s = rem_r;
            end
        end
        if (op_r[1]) begin
            div_raw_s = rmd_s;
        end else begin
            div_raw_s = quo_s;
        end
        if (word_r) begin
            div_res_s = sext32(div_raw_s);
        end else begin
            div_res_s = div_raw_s;
        end
    end

    // Control FSM with registered result. DIV ends with one extra fix-up
    // cycle (fin_r) in which the signed result is formed; divide special
    // cases skip the iterations and go straight to that fix-up cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            op_r      <= 3'd0;
            word_r    <= 1'b0;
            a_r       <= ZERO;
            b_r       <= ZERO;
            q_r       <= ZERO;
            rem_r     <= ZERO;
            dvs_r     <= ZERO;
            cnt_r     <= CNT_ZERO;
            fin_r     <= 1'b0;
            res_valid <= 1'b0;
            result    <= ZERO;
        end else if (flush) begin
            state_r   <= S_IDLE;
            cnt_r     <= CNT_ZERO;
            fin_r     <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        op_r   <= op;
                        word_r <= word;
                        a_r    <= ea_s;
                        b_r    <= eb_s;
                        if (!op[2]) begin
                            state_r <= S_MUL;
                            cnt_r   <= MUL_CNT;
                        end else if (in_special_s) begin
                            state_r <= S_DIV;
                            fin_r   <= 1'b1;
                        end else begin
                            state_r <= S_DIV;
                            fin_r   <= 1'b0;
                            cnt_r   <= word ? DIV_CNT_W : DIV_CNT_D;
                            q_r     <= word ? (mag_a_s << WS) : mag_a_s;
                            rem_r   <= ZERO;
                            dvs_r   <= mag_b_s;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_MUL: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_r   <= S_DONE;
                        result    <= mul_res_s;
                        res_valid <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                S_DIV: begin
                    if (fin_r) begin
                        state_r   <= S_DONE;
                        result    <= div_res_s;
                        res_valid <= 1'b1;
                        fin_r     <= 1'b0;
                    end else begin
                        q_r   <= q_nxt_s;
                        rem_r <= rem_nxt_s;
                        if (cnt_r == CNT_ZERO) begin
                            fin_r <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end
                    end
                end
                S_DONE: begin
                    if (!hold) begin
                        state_r   <= S_IDLE;
                        res_valid <= 1'b0;
                    end else begin
                        state_r <= S_DONE;
                    end
                end
                default: begin
                    state_r   <= S_IDLE;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
